// File: rtl/eth_bringup_seq.sv
// eth_bringup_seq
//   Power-on and link-recovery sequencer for the 1G SFP Ethernet path.
//   It holds the PHY, the MAC/PTP datapath and the SoC in reset, then
//   releases them in order. A link loss resets only the MAC side. PHY
//   bring-up is retried a bounded number of times before it declares FAIL.
//
// Ports
//   c10_clk50m        in   system clock, 50 MHz
//   clean_rst_long_n  in   asynchronous active-low reset
//   link_up_i         in   per-port link status (asynchronous, synchronized here)
//   port_en_i         in   ports required to be up (quasi-static)
//   retry_i           in   asynchronous restart request, honoured only in FAIL
//   phy_rst_n_o       out  PHY reset, active-low
//   mac_rst_n_o       out  MAC/PTP/UDP datapath reset, active-low
//   soc_rst_n_o       out  SoC reset, active-low; stays released once released
//   state_o           out  current FSM state (debug view of the sequencer)
//   retry_cnt_o       out  failed bring-up attempts since last success
//   fail_o            out  high while in FAIL
//   link_lost_o       out  one-cycle pulse on the RUN to LINK_LOST transition
//
// All outputs are registered and are decoded from the next state, so they
// change on the same edge as state_o.
module eth_bringup_seq #(
  parameter int NUM_PORTS       = 2,
  parameter int RST_CYCLES      = 2500000,
  parameter int LINK_TIMEOUT    = 50000000,
  parameter int SETTLE_CYCLES   = 500000,
  parameter int MAC_HOLD_CYCLES = 1000,
  parameter int MAX_RETRY       = 3
) (
  input  logic                 c10_clk50m,
  input  logic                 clean_rst_long_n,
  input  logic [NUM_PORTS-1:0] link_up_i,
  input  logic [NUM_PORTS-1:0] port_en_i,
  input  logic                 retry_i,
  output logic                 phy_rst_n_o,
  output logic                 mac_rst_n_o,
  output logic                 soc_rst_n_o,
  output logic [2:0]           state_o,
  output logic [3:0]           retry_cnt_o,
  output logic                 fail_o,
  output logic                 link_lost_o
);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_PHY_WAIT   = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_LINK_LOST  = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  // The timer reads N-1 in the N-th cycle of a state, so each exit compares
  // against the last cycle index of the requested duration.
  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LINK_LAST   = 32'(LINK_TIMEOUT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] MAC_LAST    = 32'(MAC_HOLD_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);

  logic [NUM_PORTS-1:0] link_meta, link_sync;
  logic                 retry_meta, retry_sync, retry_prev;
  logic                 links_ok, retry_edge;
  logic [31:0]          timer;
  state_t               state_q, state_d;
  logic [3:0]           retry_cnt_d, retry_inc;
  logic                 phy_d, mac_d, soc_d, fail_d, lost_d;

  // Two-stage synchronizers, plus one extra retry stage for edge detection.
  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      link_meta  <= '0;
      link_sync  <= '0;
      retry_meta <= 1'b0;
      retry_sync <= 1'b0;
      retry_prev <= 1'b0;
    end else begin
      link_meta  <= link_up_i;
      link_sync  <= link_meta;
      retry_meta <= retry_i;
      retry_sync <= retry_meta;
      retry_prev <= retry_sync;
    end
  end

  // Disabled ports count as up, so an all-zero enable mask is always ok.
  assign links_ok   = &(link_sync | ~port_en_i);
  assign retry_edge = retry_sync & ~retry_prev;
  assign retry_inc  = (retry_cnt_o == 4'hF) ? 4'hF : retry_cnt_o + 4'd1;

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_o;
    case (state_q)
      ST_RESET_HOLD: begin
        if (timer == RST_LAST) state_d = ST_PHY_WAIT;
      end
      ST_PHY_WAIT: begin
        if (links_ok) begin
          state_d = ST_SETTLE;
        end else if (timer == LINK_LAST) begin
          retry_cnt_d = retry_inc;
          state_d     = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET_HOLD;
        end
      end
      ST_SETTLE: begin
        // A drop wins over completion in the same cycle.
        if (!links_ok) begin
          state_d = ST_PHY_WAIT;
        end else if (timer == SETTLE_LAST) begin
          state_d     = ST_RUN;
          retry_cnt_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (!links_ok) state_d = ST_LINK_LOST;
      end
      ST_LINK_LOST: begin
        if (timer == MAC_LAST) state_d = ST_PHY_WAIT;
      end
      ST_FAIL: begin
        if (retry_edge) begin
          state_d     = ST_RESET_HOLD;
          retry_cnt_d = 4'd0;
        end
      end
      default: state_d = ST_RESET_HOLD;
    endcase

    // Output decode from the next state so outputs move with state_o.
    phy_d  = (state_d == ST_PHY_WAIT) || (state_d == ST_SETTLE) ||
             (state_d == ST_RUN) || (state_d == ST_LINK_LOST);
    mac_d  = (state_d == ST_RUN);
    soc_d  = soc_rst_n_o || (state_d == ST_RUN) || (state_d == ST_FAIL);
    fail_d = (state_d == ST_FAIL);
    lost_d = (state_q == ST_RUN) && (state_d == ST_LINK_LOST);
  end

  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      state_q     <= ST_RESET_HOLD;
      timer       <= 32'd0;
      retry_cnt_o <= 4'd0;
      phy_rst_n_o <= 1'b0;
      mac_rst_n_o <= 1'b0;
      soc_rst_n_o <= 1'b0;
      fail_o      <= 1'b0;
      link_lost_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer       <= (state_d != state_q) ? 32'd0 : timer + 32'd1;
      retry_cnt_o <= retry_cnt_d;
      phy_rst_n_o <= phy_d;
      mac_rst_n_o <= mac_d;
      soc_rst_n_o <= soc_d;
      fail_o      <= fail_d;
      link_lost_o <= lost_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_eth_bringup_seq.sv
// tb_eth_bringup_seq
//   Self-checking bench for eth_bringup_seq with short timing parameters.
//   Expected event cycles are derived arithmetically from the sequencing
//   rules (hold lengths, 3-cycle link reaction, retry counting); each state
//   change of the DUT is compared against the predicted cycle and outputs.
//   Cycle N means "just after the N-th rising edge following reset release".
module tb_eth_bringup_seq;

  localparam int RST  = 10;
  localparam int LTO  = 100;
  localparam int SET  = 20;
  localparam int MH   = 5;
  localparam int MR   = 2;
  localparam int SYNC = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] link_up;
  logic [1:0] port_en;
  logic       retry;
  logic       phy_rst_n, mac_rst_n, soc_rst_n, fail, link_lost;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [11:0] obs;

  int cyc;
  int vectors;
  int miscompares;

  eth_bringup_seq #(
    .NUM_PORTS(2), .RST_CYCLES(RST), .LINK_TIMEOUT(LTO),
    .SETTLE_CYCLES(SET), .MAC_HOLD_CYCLES(MH), .MAX_RETRY(MR)
  ) dut (
    .c10_clk50m(clk), .clean_rst_long_n(rst_n), .link_up_i(link_up),
    .port_en_i(port_en), .retry_i(retry), .phy_rst_n_o(phy_rst_n),
    .mac_rst_n_o(mac_rst_n), .soc_rst_n_o(soc_rst_n), .state_o(state),
    .retry_cnt_o(retry_cnt), .fail_o(fail), .link_lost_o(link_lost)
  );

  assign obs = {phy_rst_n, mac_rst_n, soc_rst_n, fail, link_lost, retry_cnt, state};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] pack(input logic phy, input logic mac,
                                       input logic soc, input logic fl,
                                       input logic lost, input logic [3:0] cnt,
                                       input logic [2:0] st);
    return {phy, mac, soc, fl, lost, cnt, st};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    link_up = 2'b00;
    retry   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Advance to cycle c, requiring the state to stay at hold the whole way.
  task automatic run_to(input int c, input logic [2:0] hold);
    logic bad;
    bad = (state !== hold);
    while (cyc < c) begin
      step();
      if (state !== hold) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL hold_to_%0d: state %0d seen, required to stay %0d", c, state, hold);
    end
  endtask

  // Step until state_o changes or the budget runs out (at = -1).
  task automatic wait_change(input int budget, output int at);
    logic [2:0] s0;
    s0 = state;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (state !== s0) begin
        at = cyc;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n   = 1'b0;
    port_en = 2'b11;
    link_up = 2'($urandom_range(0, 3));
    retry   = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: obs %h, required %h", obs, 12'h000);
    end
  endtask

  task automatic test_nominal(input int rise);
    int at;
    port_en = 2'b11;
    do_reset();
    wait_change(50, at);
    vectors++;
    if (at !== RST || obs !== pack(1, 0, 0, 0, 0, 0, 1)) begin
      miscompares++;
      $display("FAIL nominal_phy_release: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, RST, pack(1, 0, 0, 0, 0, 0, 1));
    end
    run_to(rise, 3'd1);
    link_up = 2'b11;
    wait_change(50, at);
    vectors++;
    if (at !== rise + SYNC || obs !== pack(1, 0, 0, 0, 0, 0, 2)) begin
      miscompares++;
      $display("FAIL nominal_settle: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, rise + SYNC, pack(1, 0, 0, 0, 0, 0, 2));
    end
    wait_change(50, at);
    vectors++;
    if (at !== rise + SYNC + SET || obs !== pack(1, 1, 1, 0, 0, 0, 3)) begin
      miscompares++;
      $display("FAIL nominal_run: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, rise + SYNC + SET, pack(1, 1, 1, 0, 0, 0, 3));
    end
  endtask

  task automatic test_settle_glitch();
    int at, s, g;
    port_en = 2'b11;
    do_reset();
    wait_change(50, at);
    run_to($urandom_range(12, 60), 3'd1);
    link_up = 2'b11;
    wait_change(50, at);
    s = at;
    g = s + $urandom_range(1, 15);
    run_to(g, 3'd2);
    link_up[1] = 1'b0;
    step();
    link_up[1] = 1'b1;
    wait_change(30, at);
    vectors++;
    if (at !== g + SYNC || obs !== pack(1, 0, 0, 0, 0, 0, 1)) begin
      miscompares++;
      $display("FAIL glitch_back_to_phy_wait: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, g + SYNC, pack(1, 0, 0, 0, 0, 0, 1));
    end
    wait_change(30, at);
    vectors++;
    if (at !== g + SYNC + 1 || obs !== pack(1, 0, 0, 0, 0, 0, 2)) begin
      miscompares++;
      $display("FAIL glitch_resettle: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, g + SYNC + 1, pack(1, 0, 0, 0, 0, 0, 2));
    end
    wait_change(50, at);
    vectors++;
    if (at !== g + SYNC + 1 + SET || obs !== pack(1, 1, 1, 0, 0, 0, 3)) begin
      miscompares++;
      $display("FAIL glitch_run: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, g + SYNC + 1 + SET, pack(1, 1, 1, 0, 0, 0, 3));
    end
  endtask

  task automatic test_timeout_fail();
    int at, pw2;
    port_en = 2'b11;
    do_reset();
    wait_change(50, at);
    // A retry request outside FAIL must not disturb PHY_WAIT.
    run_to($urandom_range(20, 80), 3'd1);
    retry = 1'b1;
    step();
    step();
    retry = 1'b0;
    wait_change(LTO + 20, at);
    vectors++;
    if (at !== RST + LTO || obs !== pack(0, 0, 0, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL timeout_1: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, RST + LTO, pack(0, 0, 0, 0, 0, 1, 0));
    end
    pw2 = RST + LTO + RST;
    wait_change(50, at);
    vectors++;
    if (at !== pw2 || obs !== pack(1, 0, 0, 0, 0, 1, 1)) begin
      miscompares++;
      $display("FAIL timeout_retry_phy_wait: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, pw2, pack(1, 0, 0, 0, 0, 1, 1));
    end
    wait_change(LTO + 20, at);
    vectors++;
    if (at !== pw2 + LTO || obs !== pack(0, 0, 1, 1, 0, MR, 5)) begin
      miscompares++;
      $display("FAIL timeout_fail: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, pw2 + LTO, pack(0, 0, 1, 1, 0, MR, 5));
    end
    run_to(cyc + 30, 3'd5);
  endtask

  task automatic test_recovery();
    int at, p;
    p = cyc;
    retry = 1'b1;
    step();
    step();
    retry = 1'b0;
    wait_change(10, at);
    vectors++;
    if (at !== p + SYNC || obs !== pack(0, 0, 1, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL recovery_reset_hold: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, p + SYNC, pack(0, 0, 1, 0, 0, 0, 0));
    end
    link_up = 2'b11;
    wait_change(30, at);
    vectors++;
    if (at !== p + SYNC + RST || obs !== pack(1, 0, 1, 0, 0, 0, 1)) begin
      miscompares++;
      $display("FAIL recovery_phy_wait: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, p + SYNC + RST, pack(1, 0, 1, 0, 0, 0, 1));
    end
    wait_change(10, at);
    vectors++;
    if (at !== p + SYNC + RST + 1 || obs !== pack(1, 0, 1, 0, 0, 0, 2)) begin
      miscompares++;
      $display("FAIL recovery_settle: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, p + SYNC + RST + 1, pack(1, 0, 1, 0, 0, 0, 2));
    end
    wait_change(50, at);
    vectors++;
    if (at !== p + SYNC + RST + 1 + SET || obs !== pack(1, 1, 1, 0, 0, 0, 3)) begin
      miscompares++;
      $display("FAIL recovery_run: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, p + SYNC + RST + 1 + SET, pack(1, 1, 1, 0, 0, 0, 3));
    end
  endtask

  task automatic test_link_loss();
    int at, d;
    d = cyc + $urandom_range(2, 20);
    run_to(d, 3'd3);
    link_up[0] = 1'b0;
    wait_change(10, at);
    vectors++;
    if (at !== d + SYNC || obs !== pack(1, 0, 1, 0, 1, 0, 4)) begin
      miscompares++;
      $display("FAIL loss_link_lost: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, d + SYNC, pack(1, 0, 1, 0, 1, 0, 4));
    end
    step();
    vectors++;
    if (obs !== pack(1, 0, 1, 0, 0, 0, 4)) begin
      miscompares++;
      $display("FAIL loss_pulse_width: obs %h, required %h", obs, pack(1, 0, 1, 0, 0, 0, 4));
    end
    wait_change(20, at);
    vectors++;
    if (at !== d + SYNC + MH || obs !== pack(1, 0, 1, 0, 0, 0, 1)) begin
      miscompares++;
      $display("FAIL loss_mac_hold: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, d + SYNC + MH, pack(1, 0, 1, 0, 0, 0, 1));
    end
    link_up[0] = 1'b1;
    wait_change(10, at);
    wait_change(50, at);
    vectors++;
    if (at !== d + SYNC + MH + SYNC + SET || obs !== pack(1, 1, 1, 0, 0, 0, 3)) begin
      miscompares++;
      $display("FAIL loss_rerun: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, d + SYNC + MH + SYNC + SET, pack(1, 1, 1, 0, 0, 0, 3));
    end
  endtask

  task automatic test_masking_mid_reset();
    int at, rise;
    port_en = 2'b01;
    do_reset();
    rise = $urandom_range(12, 80);
    wait_change(50, at);
    run_to(rise, 3'd1);
    link_up = 2'b01;
    wait_change(50, at);
    wait_change(50, at);
    vectors++;
    if (at !== rise + SYNC + SET || obs !== pack(1, 1, 1, 0, 0, 0, 3)) begin
      miscompares++;
      $display("FAIL mask_run: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, rise + SYNC + SET, pack(1, 1, 1, 0, 0, 0, 3));
    end
    port_en = 2'b11;
    do_reset();
    wait_change(50, at);
    run_to(30, 3'd1);
    link_up = 2'b11;
    wait_change(50, at);
    run_to(cyc + $urandom_range(2, 15), 3'd2);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset_async: obs %h, required %h", obs, 12'h000);
    end
    do_reset();
    link_up = 2'b11;
    wait_change(50, at);
    vectors++;
    if (at !== RST || obs !== pack(1, 0, 0, 0, 0, 0, 1)) begin
      miscompares++;
      $display("FAIL mid_reset_restart: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, RST, pack(1, 0, 0, 0, 0, 0, 1));
    end
    wait_change(10, at);
    wait_change(50, at);
    vectors++;
    if (at !== RST + 1 + SET || obs !== pack(1, 1, 1, 0, 0, 0, 3)) begin
      miscompares++;
      $display("FAIL mid_reset_run: cycle %0d obs %h, required cycle %0d obs %h",
               at, obs, RST + 1 + SET, pack(1, 1, 1, 0, 0, 0, 3));
    end
  endtask

  // sequence and final report
  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    link_up     = 2'b00;
    port_en     = 2'b11;
    retry       = 1'b0;
    test_reset();
    test_nominal(30);
    test_nominal($urandom_range(12, 80));
    test_settle_glitch();
    test_timeout_fail();
    test_recovery();
    test_link_loss();
    test_masking_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_bringup_seq.md
# eth_bringup_seq

Power-on and link-recovery sequencer for the 1G SFP Ethernet path, in the 50 MHz system clock domain. It holds the PHY, the MAC/PTP datapath and the SoC in reset, then releases them in order: PHY, wait for link, link settle, then MAC and SoC. It recovers from link loss by resetting only the MAC side, and retries PHY bring-up a bounded number of times before declaring failure.

## Interface
Parameters:
- NUM_PORTS, 2, number of SFP ports monitored
- RST_CYCLES, 2500000, initial reset hold (50 ms at 50 MHz)
- LINK_TIMEOUT, 50000000, maximum PHY_WAIT duration before retry (1 s)
- SETTLE_CYCLES, 500000, consecutive all-links-up cycles required (10 ms)
- MAC_HOLD_CYCLES, 1000, MAC reset pulse length on link loss
- MAX_RETRY, 3, PHY bring-up attempts before FAIL (1..15)

Ports:
- c10_clk50m  in  1  system clock, 50 MHz
- clean_rst_long_n  in  1  reset, asynchronous, active-low
- link_up_i  in  NUM_PORTS  per-port link status, asynchronous to c10_clk50m
- port_en_i  in  NUM_PORTS  ports that must be up; quasi-static
- retry_i  in  1  asynchronous request to restart from FAIL
- phy_rst_n_o  out  1  PHY reset, active-low
- mac_rst_n_o  out  1  MAC/PTP/UDP datapath reset, active-low
- soc_rst_n_o  out  1  SoC reset, active-low, sticky once released
- state_o  out  3  current state encoding
- retry_cnt_o  out  4  failed bring-up attempts since last success
- fail_o  out  1  high while in FAIL
- link_lost_o  out  1  one-cycle pulse on RUN-to-LINK_LOST transition

## Operation
- link_up_i and retry_i each pass through a 2-FF synchronizer. retry edge is the rising edge of the synchronized signal.
- links_ok = &(link_sync | ~port_en_i). port_en_i == 0 makes links_ok constantly 1.
- One 32-bit timer is cleared on every state transition and increments in every other cycle.
- States (state_o): RESET_HOLD=0, PHY_WAIT=1, SETTLE=2, RUN=3, LINK_LOST=4, FAIL=5.
- RESET_HOLD: phy, mac and soc resets follow the table of outputs below. After RST_CYCLES cycles, go to PHY_WAIT.
- PHY_WAIT: phy_rst_n_o=1.
  - links_ok: go to SETTLE.
  - Otherwise, timer reaches LINK_TIMEOUT-1: retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; else go to RESET_HOLD.
- SETTLE:
  - links_ok drops: go to PHY_WAIT. Timer restarts; retry_cnt is unchanged.
  - links_ok held SETTLE_CYCLES consecutive cycles: go to RUN and clear retry_cnt.
- RUN: mac_rst_n_o=1, soc_rst_n_o=1. links_ok=0: go to LINK_LOST and pulse link_lost_o.
- LINK_LOST: mac_rst_n_o=0; phy and soc stay released. After MAC_HOLD_CYCLES, go to PHY_WAIT.
- FAIL: phy_rst_n_o=0, mac_rst_n_o=0, soc_rst_n_o=1 (the SoC can report over UART), fail_o=1. A retry edge clears retry_cnt and goes to RESET_HOLD.
- soc_rst_n_o is set on the first entry to RUN or FAIL and is cleared only by clean_rst_long_n.
- retry edges outside FAIL are ignored.

## Timing
- All outputs are registered and change on the same edge as state_o.
- Reset values: phy_rst_n_o=0, mac_rst_n_o=0, soc_rst_n_o=0, state_o=0, retry_cnt_o=0, fail_o=0, link_lost_o=0, timer=0, synchronizers=0.
- RESET_HOLD lasts exactly RST_CYCLES cycles from reset release or state entry.
- Link input to state reaction: 3 cycles (2 sync stages plus 1 state register).
- SETTLE to RUN: exactly SETTLE_CYCLES cycles after SETTLE entry, if links stay up.
- PHY_WAIT timeout: exit on cycle LINK_TIMEOUT after entry.
- A link drop in the same cycle as SETTLE completion means links_ok=0 that cycle; the block returns to PHY_WAIT.
- clean_rst_long_n asserted in any state forces all reset values immediately (asynchronous); the sequence restarts at RESET_HOLD.
- retry_cnt saturates at 15.

## Test plan
All scenarios use RST_CYCLES=10, LINK_TIMEOUT=100, SETTLE_CYCLES=20, MAC_HOLD_CYCLES=5, MAX_RETRY=2, port_en_i=2'b11.
- Nominal bring-up: release reset, raise both links at cycle 30.
  - phy_rst_n_o rises at cycle 10.
  - SETTLE is entered at cycle 33.
  - mac_rst_n_o, soc_rst_n_o and state_o=3 appear at cycle 53.
- Settle glitch: drop link_up_i[1] for 1 cycle during SETTLE.
  - Block returns to PHY_WAIT; retry_cnt_o stays 0.
  - RUN is reached only after 20 clean cycles.
- Timeout and FAIL: links never rise.
  - Two PHY_WAIT timeouts occur.
  - retry_cnt_o=1, then 2.
  - state_o=5, fail_o=1, soc_rst_n_o=1, phy_rst_n_o=0.
- Recovery from FAIL: pulse retry_i, then raise links.
  - retry_cnt_o=0 and state_o=0.
  - RUN is reached normally.
- Link loss in RUN: drop link_up_i[0].
  - link_lost_o pulses for 1 cycle 3 cycles after the drop.
  - mac_rst_n_o is low for 5 cycles; phy_rst_n_o and soc_rst_n_o stay 1.
  - state_o=1 afterwards.
- Port masking and mid-run reset:
  - port_en_i=2'b01 with link 1 down: RUN is reached.
  - Assert clean_rst_long_n low mid-SETTLE: all outputs go to 0 asynchronously.
